// File: rtl/pet_bus_pkg.sv
// Shared types and constants for the PET bus cycle sequencer and its neighbours.
package pet_bus_pkg;

  // Bus cycle phases.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } bus_state_t;

  localparam int DEF_STROBE_CYCLES  = 2;
  localparam int DEF_VRAM_ADDR_BITS = 10;
  localparam logic [16:0] MAGIC_BASE = 17'h0E800;

  // Decoder enables and attributes, captured once per cycle.
  typedef struct packed {
    logic ram;
    logic magic;
    logic pia1;
    logic pia2;
    logic via;
    logic crtc;
    logic io;
    logic mirrored;
    logic readonly;
  } decode_t;

  // Display-RAM mirroring: clear bits [11:vbits], keep everything else.
  function automatic logic [16:0] mirror_addr(input logic [16:0] a, input int vbits);
    logic [16:0] r;
    r = a;
    for (int i = 0; i < 12; i++) begin
      if (i >= vbits) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_control.sv
// One memory/IO bus cycle per request: latch address, wait for the decoder,
// then setup / strobe / hold with fixed widths. Owns the MAGIC register.
//
// Handshake: req is a request strobe sampled only in IDLE; once taken, the
// cycle runs to completion and ack pulses for exactly one clock in the first
// IDLE cycle afterwards. req seen in any other state is dropped, not queued.
// A req held high during the ack cycle starts the next cycle at that edge.
module bus_cycle_control
  import pet_bus_pkg::*;
#(
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int VRAM_ADDR_BITS = DEF_VRAM_ADDR_BITS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [16:0] req_addr,
  input  logic        req_rw_b,
  input  logic [7:0]  req_data,
  output logic        ack,
  output logic        wr_dropped,
  output logic [16:0] bus_addr,
  input  logic        ram_enable,
  input  logic        magic_enable,
  input  logic        pia1_enable,
  input  logic        pia2_enable,
  input  logic        via_enable,
  input  logic        crtc_enable,
  input  logic        io_enable,
  input  logic        is_mirrored,
  input  logic        is_readonly,
  output logic [16:0] ram_addr,
  output logic        ram_oe_b,
  output logic        ram_we_b,
  output logic        pia1_cs_b,
  output logic        pia2_cs_b,
  output logic        via_cs_b,
  output logic        crtc_cs_b,
  output logic        io_rw_b,
  output logic [7:0]  magic_reg,
  output bus_state_t  dbg_state
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_STROBE = CW'(STROBE_CYCLES - 1);

  bus_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [16:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [7:0]    data_q, data_d;
  decode_t       dec_q, dec_d, dec_in;
  logic          ack_q, ack_d;
  logic          drop_q, drop_d;
  logic [7:0]    magic_q, magic_d;

  logic          any_en;
  logic          io_phase;
  logic          io_sel;

  assign dec_in = {ram_enable, magic_enable, pia1_enable, pia2_enable, via_enable,
                   crtc_enable, io_enable, is_mirrored, is_readonly};

  assign any_en = dec_q.ram | dec_q.magic | dec_q.pia1 | dec_q.pia2 |
                  dec_q.via | dec_q.crtc | dec_q.io;

  // Selects are live from SETUP through HOLD; strobes only during STROBE.
  assign io_phase = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
  assign io_sel   = dec_q.pia1 | dec_q.pia2 | dec_q.via | dec_q.crtc;

  // All bus outputs decode from registered state and latched attributes only,
  // so reset forces every strobe and select inactive without waiting for a clock.
  assign bus_addr   = addr_q;
  assign ram_addr   = dec_q.mirrored ? mirror_addr(addr_q, VRAM_ADDR_BITS) : addr_q;
  assign ram_oe_b   = !((state == ST_STROBE) && rw_q && dec_q.ram);
  assign ram_we_b   = !((state == ST_STROBE) && !rw_q && dec_q.ram && !dec_q.readonly);
  assign pia1_cs_b  = !(io_phase && dec_q.pia1);
  assign pia2_cs_b  = !(io_phase && dec_q.pia2);
  assign via_cs_b   = !(io_phase && dec_q.via);
  assign crtc_cs_b  = !(io_phase && dec_q.crtc);
  assign io_rw_b    = (io_phase && io_sel) ? rw_q : 1'b1;
  assign ack        = ack_q;
  assign wr_dropped = drop_q;
  assign magic_reg  = magic_q;
  assign dbg_state  = state;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      data_q  <= '0;
      dec_q   <= '0;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
      magic_q <= 8'h00;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      dec_q   <= dec_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
      magic_q <= magic_d;
    end
  end

  // Next-state and next-register values for the bus cycle sequence.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    rw_d    = rw_q;
    data_d  = data_q;
    dec_d   = dec_q;
    ack_d   = 1'b0;
    drop_d  = 1'b0;
    magic_d = magic_q;
    case (state)
      ST_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          rw_d    = req_rw_b;
          data_d  = req_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Decoder outputs for the new bus_addr are settled by the end of this cycle.
        dec_d   = dec_in;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt == LAST_STROBE) begin
          if (!rw_q && dec_q.magic) magic_d = data_q;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        ack_d   = 1'b1;
        drop_d  = !rw_q && (dec_q.readonly || !any_en);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
